// File: rtl/vm_pkg.sv
// Shared definitions for the multi-item vending controller.
//   - Coin codes (shared by the coin input, the change output and the coin_rej echo).
//   - coin_val(): coin code -> value in half-units.
//   - vm_state_t: controller FSM states.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_TWO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    VEND,
    CHANGE
  } vm_state_t;

  function automatic logic [2:0] coin_val(input logic [1:0] code);
    case (code)
      COIN_HALF: coin_val = 3'd1;
      COIN_ONE:  coin_val = 3'd2;
      COIN_TWO:  coin_val = 3'd4;
      default:   coin_val = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_disp.sv
// Greedy coin dispenser, shared by the change and the refund paths.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_val as the amount still owed
//   emit      : pay out one coin this edge (from load_val when load is also set)
//   load_val  : amount owed, half-units
//   change    : registered coin paid out, COIN_NONE when not emitting
//   done      : nothing left to pay; while a coin is on change it was the last one
module vm_change_disp
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                emit,
  input  logic [CREDIT_W-1:0] load_val,
  output logic [1:0]          change,
  output logic                done
);

  logic [CREDIT_W-1:0] remaining;
  logic [CREDIT_W-1:0] src;
  logic [1:0]          coin_sel;

  // Largest coin that still fits in what is owed.
  always_comb begin
    src = load ? load_val : remaining;
    if (src >= CREDIT_W'(4))      coin_sel = COIN_TWO;
    else if (src >= CREDIT_W'(2)) coin_sel = COIN_ONE;
    else if (src != '0)           coin_sel = COIN_HALF;
    else                          coin_sel = COIN_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      change    <= COIN_NONE;
    end else begin
      change <= emit ? coin_sel : COIN_NONE;
      if (emit)      remaining <= src - CREDIT_W'(coin_val(coin_sel));
      else if (load) remaining <= load_val;
    end
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: credit accumulation with saturation, per-item
// price lookup, vend / deny / cancel handling, and a registered greedy coin
// stream for change and refunds.
// Optional feature macro: VM_COIN_REJECT_EN (adds coin_rej; coins that arrive
// while busy or would overflow MAX_CREDIT are echoed back instead of credited).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   coin            : inserted coin code, sampled every edge
//   sel_vld/sel_item: item request strobe and index
//   cancel          : refund request
//   sell/sell_item  : 1-cycle dispense pulse and item index
//   deny            : 1-cycle refusal pulse
//   change          : returned coin this cycle
//   busy            : high while vending or paying out
//   credit          : current credit in half-units (0 while busy)
//   coin_rej        : rejected coin echo (VM_COIN_REJECT_EN only)
// Handshake: sel_vld and cancel are single-cycle strobes with no ready; they are
// acted on only in a cycle where busy is low and are dropped otherwise.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                          CREDIT_W   = 6,
  parameter int                          N_ITEMS    = 4,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {6'd2, 6'd5, 6'd4, 6'd3},
  parameter int                          MAX_CREDIT = 10,
  localparam int                         IDX_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_vld,
  input  logic [IDX_W-1:0]    sel_item,
  input  logic                cancel,
  output logic                sell,
  output logic [IDX_W-1:0]    sell_item,
  output logic                deny,
  output logic [1:0]          change,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
`ifdef VM_COIN_REJECT_EN
  ,
  output logic [1:0]          coin_rej
`endif
);

  localparam logic [CREDIT_W:0]   MAX_W = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

  vm_state_t           state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                sell_n, deny_n, busy_n;
  logic [IDX_W-1:0]    item_n;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] eff;
  logic [CREDIT_W-1:0] price;
  logic                item_ok;
  logic                disp_load, disp_emit, disp_done;
  logic [CREDIT_W-1:0] disp_val;
`ifdef VM_COIN_REJECT_EN
  logic                over;
  logic [1:0]          rej_n;
`endif

  // Effective credit: the coin of this cycle counts before any request.
  always_comb begin
    sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val(coin));
`ifdef VM_COIN_REJECT_EN
    over  = (sum > MAX_W);
    eff   = over ? credit : sum[CREDIT_W-1:0];
    rej_n = ((state != IDLE) || over) ? coin : COIN_NONE;
`else
    eff   = (sum > MAX_W) ? MAX_C : sum[CREDIT_W-1:0];
`endif
  end

  // Price lookup; indices beyond N_ITEMS leave item_ok low.
  always_comb begin
    price   = '0;
    item_ok = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (int'(sel_item) == i) begin
        price   = PRICES[i*CREDIT_W +: CREDIT_W];
        item_ok = 1'b1;
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n   = state;
    credit_n  = credit;
    sell_n    = 1'b0;
    deny_n    = 1'b0;
    item_n    = sell_item;
    disp_load = 1'b0;
    disp_emit = 1'b0;
    disp_val  = eff;
    case (state)
      IDLE: begin
        if (cancel) begin
          // Refund starts paying out immediately; eff == 0 means nothing to do.
          if (eff != '0) begin
            state_n   = CHANGE;
            credit_n  = '0;
            disp_load = 1'b1;
            disp_emit = 1'b1;
          end
        end else if (sel_vld) begin
          if (item_ok && (eff >= price)) begin
            state_n   = VEND;
            credit_n  = '0;
            sell_n    = 1'b1;
            item_n    = sel_item;
            disp_load = 1'b1;
            disp_val  = eff - price;
          end else begin
            deny_n   = 1'b1;
            credit_n = eff;
          end
        end else begin
          credit_n = eff;
        end
      end
      VEND: begin
        if (!disp_done) begin
          state_n   = CHANGE;
          disp_emit = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CHANGE: begin
        // done here means the coin now on change is the last one.
        if (disp_done) state_n = IDLE;
        else           disp_emit = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      credit    <= '0;
      sell      <= 1'b0;
      sell_item <= '0;
      deny      <= 1'b0;
      busy      <= 1'b0;
`ifdef VM_COIN_REJECT_EN
      coin_rej  <= COIN_NONE;
`endif
    end else begin
      state     <= state_n;
      credit    <= credit_n;
      sell      <= sell_n;
      sell_item <= item_n;
      deny      <= deny_n;
      busy      <= busy_n;
`ifdef VM_COIN_REJECT_EN
      coin_rej  <= rej_n;
`endif
    end
  end

  vm_change_disp #(
    .CREDIT_W (CREDIT_W)
  ) u_disp (
    .clk      (clk),
    .rst      (rst),
    .load     (disp_load),
    .emit     (disp_emit),
    .load_val (disp_val),
    .change   (change),
    .done     (disp_done)
  );

endmodule

// File: tb/tb_vending_machine_multi.sv
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_vld;
  logic [1:0] sel_item;
  logic       cancel;
  logic       sell;
  logic [1:0] sell_item;
  logic       deny;
  logic [1:0] change;
  logic       busy;
  logic [5:0] credit;
`ifdef VM_COIN_REJECT_EN
  logic [1:0] coin_rej;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  vending_machine_multi dut (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .sel_vld   (sel_vld),
    .sel_item  (sel_item),
    .cancel    (cancel),
    .sell      (sell),
    .sell_item (sell_item),
    .deny      (deny),
    .change    (change),
    .busy      (busy),
    .credit    (credit)
`ifdef VM_COIN_REJECT_EN
    ,
    .coin_rej  (coin_rej)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Works in money terms: a vend or refund becomes a planned list of per-cycle
  // outputs (sell record then greedy coins); busy lasts while the plan plays out.
  localparam int MAXC = 10;
  int price_tab[4] = '{3, 4, 5, 2};

  typedef struct {
    bit s;
    int item;
    int chg;
  } plan_t;

  plan_t plan[$];
  int    m_credit;
  bit    m_busy;
  int    m_item;
  int    e_sell, e_item, e_deny, e_chg, e_busy, e_credit, e_rej;

  function automatic int val_of(input int c);
    if (c == 1) return 1;
    if (c == 2) return 2;
    if (c == 3) return 4;
    return 0;
  endfunction

  function automatic void push_coins(input int amount);
    plan_t p;
    int    r;
    r = amount;
    while (r > 0) begin
      p.s = 0; p.item = 0;
      if (r >= 4)      begin p.chg = 3; r -= 4; end
      else if (r >= 2) begin p.chg = 2; r -= 2; end
      else             begin p.chg = 1; r -= 1; end
      plan.push_back(p);
    end
  endfunction

  function automatic void model_step(input int c, input int sv, input int si, input int ca, input int r);
    plan_t p;
    int    eff;
    int    s;
    e_sell = 0; e_deny = 0; e_chg = 0; e_rej = 0;
    if (r != 0) begin
      m_credit = 0; m_busy = 0; m_item = 0;
      plan.delete();
    end else if (m_busy) begin
      e_rej = c;
      if (plan.size() > 0) begin
        p = plan.pop_front();
        e_sell = p.s;
        if (p.s) m_item = p.item;
        e_chg = p.chg;
      end else begin
        m_busy = 0;
      end
    end else begin
      s = m_credit + val_of(c);
`ifdef VM_COIN_REJECT_EN
      if (s > MAXC) begin eff = m_credit; e_rej = c; end
      else eff = s;
`else
      eff = (s > MAXC) ? MAXC : s;
`endif
      if (ca != 0) begin
        if (eff > 0) begin push_coins(eff); m_credit = 0; end
      end else if (sv != 0) begin
        if (si < 4 && eff >= price_tab[si]) begin
          p.s = 1; p.item = si; p.chg = 0;
          plan.push_back(p);
          push_coins(eff - price_tab[si]);
          m_credit = 0;
        end else begin
          e_deny = 1;
          m_credit = eff;
        end
      end else begin
        m_credit = eff;
      end
      if (plan.size() > 0) begin
        p = plan.pop_front();
        e_sell = p.s;
        if (p.s) m_item = p.item;
        e_chg = p.chg;
        m_busy = 1;
      end
    end
    e_busy   = m_busy;
    e_item   = m_item;
    e_credit = m_credit;
  endfunction

  // ---------------- driver / checker ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int c, input int sv, input int si, input int ca, input int r);
    coin = 2'(c); sel_vld = 1'(sv); sel_item = 2'(si); cancel = 1'(ca); rst = 1'(r);
    @(posedge clk);
    model_step(c, sv, si, ca, r);
    cyc++;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_sell"}, 8'(sell), 8'(e_sell));
    if (e_sell != 0) check({tag, "_item"}, 8'(sell_item), 8'(e_item));
    check({tag, "_deny"}, 8'(deny), 8'(e_deny));
    check({tag, "_change"}, 8'(change), 8'(e_chg));
    check({tag, "_busy"}, 8'(busy), 8'(e_busy));
    check({tag, "_credit"}, 8'(credit), 8'(e_credit));
`ifdef VM_COIN_REJECT_EN
    check({tag, "_rej"}, 8'(coin_rej), 8'(e_rej));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int coin, sv, si, ca, r;
    int e_sell, e_item, e_deny, e_chg, e_busy, e_credit;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int c, input int sv, input int si, input int ca, input int r,
                              input int s, input int it, input int d, input int ch, input int b,
                              input int cr);
    vec_t t;
    t.coin = c; t.sv = sv; t.si = si; t.ca = ca; t.r = r;
    t.e_sell = s; t.e_item = it; t.e_deny = d; t.e_chg = ch; t.e_busy = b; t.e_credit = cr;
    vecs.push_back(t);
  endfunction

  logic [1:0] exp_q[$];

  initial begin
    coin = 0; sel_vld = 0; sel_item = 0; cancel = 0; rst = 1;

    // reset state
    add(0,0,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);
    // 1: 0.5 x4, sel 0 (1.5) -> sell, change 01
    add(1,0,0,0,0, 0,0,0,0,0,1);
    add(1,0,0,0,0, 0,0,0,0,0,2);
    add(1,0,0,0,0, 0,0,0,0,0,3);
    add(1,0,0,0,0, 0,0,0,0,0,4);
    add(0,1,0,0,0, 1,0,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // 2: 1.0, 0.5, 1.0, sel 0 -> change 10
    add(2,0,0,0,0, 0,0,0,0,0,2);
    add(1,0,0,0,0, 0,0,0,0,0,3);
    add(2,0,0,0,0, 0,0,0,0,0,5);
    add(0,1,0,0,0, 1,0,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,2,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // 3: 0.5 then sel 1 (2.0) -> deny, credit kept; then refund
    add(1,0,0,0,0, 0,0,0,0,0,1);
    add(0,1,1,0,0, 0,0,1,0,0,1);
    add(0,0,0,0,0, 0,0,0,0,0,1);
    add(0,0,0,1,0, 0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // 4: credit 7 then cancel -> 11,10,01; coin/sel/cancel while busy ignored
    add(3,0,0,0,0, 0,0,0,0,0,4);
    add(2,0,0,0,0, 0,0,0,0,0,6);
    add(1,0,0,0,0, 0,0,0,0,0,7);
    add(0,0,0,1,0, 0,0,0,3,1,0);
    add(3,1,2,0,0, 0,0,0,2,1,0);
    add(0,0,0,1,0, 0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // 5: saturation at 10 (no overflowing coin credited in either build)
    add(3,0,0,0,0, 0,0,0,0,0,4);
    add(3,0,0,0,0, 0,0,0,0,0,8);
    add(2,0,0,0,0, 0,0,0,0,0,10);
    add(3,0,0,0,0, 0,0,0,0,0,10);
    add(1,0,0,0,0, 0,0,0,0,0,10);
    add(0,0,0,1,0, 0,0,0,3,1,0);
    add(0,0,0,0,0, 0,0,0,3,1,0);
    add(0,0,0,0,0, 0,0,0,2,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // 6: credit 9, sel 3, reset during first change coin
    add(3,0,0,0,0, 0,0,0,0,0,4);
    add(3,0,0,0,0, 0,0,0,0,0,8);
    add(1,0,0,0,0, 0,0,0,0,0,9);
    add(0,1,3,0,0, 1,3,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,3,1,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // same-cycle coin and request: coin counts first
    add(3,1,3,0,0, 1,3,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,2,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0,0,1);
    add(2,1,0,0,0, 1,0,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // exact price, no change: VEND returns straight to IDLE
    add(2,0,0,0,0, 0,0,0,0,0,2);
    add(1,0,0,0,0, 0,0,0,0,0,3);
    add(0,1,0,0,0, 1,0,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // cancel with nothing credited; cancel with a same-cycle coin; cancel beats sel
    add(0,0,0,1,0, 0,0,0,0,0,0);
    add(1,0,0,1,0, 0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(2,0,0,0,0, 0,0,0,0,0,2);
    add(0,1,3,1,0, 0,0,0,2,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].coin, vecs[i].sv, vecs[i].si, vecs[i].ca, vecs[i].r);
      check($sformatf("v%0d_sell", i), 8'(sell), 8'(vecs[i].e_sell));
      if (vecs[i].e_sell != 0) check($sformatf("v%0d_item", i), 8'(sell_item), 8'(vecs[i].e_item));
      check($sformatf("v%0d_deny", i), 8'(deny), 8'(vecs[i].e_deny));
      check($sformatf("v%0d_change", i), 8'(change), 8'(vecs[i].e_chg));
      check($sformatf("v%0d_busy", i), 8'(busy), 8'(vecs[i].e_busy));
      check($sformatf("v%0d_credit", i), 8'(credit), 8'(vecs[i].e_credit));
    end

    // Hand sequence: credit 10, buy item 1 (2.0) -> 3.0 back as 11 then 10.
    begin
      bit done;
      done = 0;
      step(3,0,0,0,0); check_model("h_c1");
      step(3,0,0,0,0); check_model("h_c2");
      step(2,0,0,0,0); check_model("h_c3");
      step(0,1,1,0,0); check_model("h_sel");
      check("h_sell", 8'(sell), 8'd1);
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b10);
      for (int k = 0; k < 8 && !done; k++) begin
        step(0,0,0,0,0);
        check_model("h_wait");
        if (change != 2'b00) begin
          if (exp_q.size() == 0) check("h_extra_coin", 8'(change), 8'd0);
          else check("h_coin", 8'(change), 8'(exp_q.pop_front()));
        end
        if (!busy) done = 1;
      end
      check("h_done_in_budget", 8'(done), 8'd1);
      check("h_coins_left", 8'(exp_q.size()), 8'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int c, sv, si, ca, r;
      c  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      sv = ($urandom_range(0, 3) == 0) ? 1 : 0;
      si = $urandom_range(0, 3);
      ca = ($urandom_range(0, 11) == 0) ? 1 : 0;
      r  = ($urandom_range(0, 79) == 0) ? 1 : 0;
      step(c, sv, si, ca, r);
      check_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
